riscv_alu_issue: RTL and testbench

//  Execute-stage issue buffer directly upstream of the ALU. Accepts decoded ops from decode
//  (valid/ready), holds them in a 2-entry skid buffer and resolves operands (rs1/pc/zero,
//  rs2/imm) with forwarding from the ALU result and from the writeback register.

---
 rtl/riscv_alu_issue.sv | 215 +++++++++++++++++++++
 tb/tb_riscv_alu_issue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_issue.sv
// rtl/riscv_alu_issue.sv - execute-stage issue buffer with operand forwarding ahead of a registered ALU
//
// Decoded ops enter through a 2-entry skid buffer (E head, S skid). The head
// issues to the ALU when not held or flushed. Operands come from E, with
// register sources forwarded from the in-flight ALU result (X) or the
// writeback register (W). Because the ALU registers its result, the issued
// op's rd/we tag is carried in X for one cycle. It is then re-joined with
// alu_p_i in W.
//
// Ports:
//   clk, rstb                 clock, synchronous active-high reset
//   in_valid/in_ready         decode handshake (in_ready registered)
//   in_op, in_*_val, in_imm,  decoded op payload
//   in_pc, in_*_addr, in_rd_we,
//   in_a_sel, in_b_sel
//   hold_i, flush_i           downstream stall, pipeline flush
//   alu_op_o, alu_a_o/b_o     op and resolved operands to the ALU
//   alu_p_i                   ALU result of the op issued last cycle
//   wb_valid_o, wb_we_o,      writeback entry
//   wb_rd_o, wb_data_o
module riscv_alu_issue #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_rd_we,
  input  logic [1:0]        in_a_sel,
  input  logic              in_b_sel,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [3:0]        alu_op_o,
  output logic [XLEN-1:0]   alu_a_o,
  output logic [XLEN-1:0]   alu_b_o,
  input  logic [XLEN-1:0]   alu_p_i,
  output logic              wb_valid_o,
  output logic              wb_we_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o
);

  // ALU bubble code; real op codes pass through untouched.
  localparam logic [3:0] ALU_IDLE = 4'hF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [1:0]        a_sel;
    logic              b_sel;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              we;
  } entry_t;

  state_t            state_q, state_d;
  logic              in_ready_q;
  entry_t            e_q, s_q, in_ent;
  logic              load_e_in, load_e_s, load_s_in;
  logic              accept, issue;

  logic              x_v, x_we;
  logic [REG_AW-1:0] x_rd;
  logic              w_v, w_we;
  logic [REG_AW-1:0] w_rd;
  logic [XLEN-1:0]   w_data;

  logic [XLEN-1:0]   rs1_fwd, rs2_fwd, a_res, b_res;

  assign in_ent = '{op: in_op, a_sel: in_a_sel, b_sel: in_b_sel,
                    rs1_val: in_rs1_val, rs2_val: in_rs2_val, imm: in_imm, pc: in_pc,
                    rs1: in_rs1_addr, rs2: in_rs2_addr, rd: in_rd_addr, we: in_rd_we};

  assign accept = in_valid & in_ready_q;
  // E is valid in every state but EMPTY; reset also suppresses issue so the
  // ALU sees a bubble while rstb is high.
  assign issue  = (state_q != EMPTY) & ~hold_i & ~flush_i & ~rstb;

  // State register
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Next-state and buffer load controls. Flush wins over issue and accept.
  always_comb begin
    state_d   = state_q;
    load_e_in = 1'b0;
    load_e_s  = 1'b0;
    load_s_in = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_e_in = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (issue && accept) begin
            load_e_in = 1'b1;
          end else if (issue) begin
            state_d = EMPTY;
          end else if (accept) begin
            load_s_in = 1'b1;
            state_d   = TWO;
          end
        end
        TWO: begin
          // in_ready is low here, so only the skid entry can move.
          if (issue) begin
            load_e_s = 1'b1;
            state_d  = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Buffer payload: validity lives in the state, so no reset needed.
  always_ff @(posedge clk) begin
    if (load_e_in) begin
      e_q <= in_ent;
    end else if (load_e_s) begin
      e_q <= s_q;
    end
    if (load_s_in) begin
      s_q <= in_ent;
    end
  end

  // In-flight tag and writeback register. W samples every cycle so an op
  // already in the ALU retires even across a flush.
  always_ff @(posedge clk) begin
    if (rstb) begin
      x_v    <= 1'b0;
      x_we   <= 1'b0;
      x_rd   <= '0;
      w_v    <= 1'b0;
      w_we   <= 1'b0;
      w_rd   <= '0;
      w_data <= '0;
    end else begin
      x_v    <= issue;
      x_we   <= e_q.we;
      x_rd   <= e_q.rd;
      w_v    <= x_v;
      w_we   <= x_we;
      w_rd   <= x_rd;
      w_data <= alu_p_i;
    end
  end

  // Operand resolution. The newer result (X) shadows W; x0 never forwards.
  always_comb begin
    rs1_fwd = e_q.rs1_val;
    if (e_q.rs1 != '0 && x_v && x_we && x_rd == e_q.rs1) begin
      rs1_fwd = alu_p_i;
    end else if (e_q.rs1 != '0 && w_v && w_we && w_rd == e_q.rs1) begin
      rs1_fwd = w_data;
    end

    rs2_fwd = e_q.rs2_val;
    if (e_q.rs2 != '0 && x_v && x_we && x_rd == e_q.rs2) begin
      rs2_fwd = alu_p_i;
    end else if (e_q.rs2 != '0 && w_v && w_we && w_rd == e_q.rs2) begin
      rs2_fwd = w_data;
    end

    case (e_q.a_sel)
      2'b01:   a_res = e_q.pc;
      2'b10:   a_res = '0;
      default: a_res = rs1_fwd;
    endcase
    b_res = e_q.b_sel ? e_q.imm : rs2_fwd;
  end

  assign in_ready   = in_ready_q;
  assign alu_op_o   = issue ? e_q.op : ALU_IDLE;
  assign alu_a_o    = rstb ? '0 : a_res;
  assign alu_b_o    = rstb ? '0 : b_res;

  assign wb_valid_o = w_v;
  assign wb_we_o    = w_v & w_we;
  assign wb_rd_o    = w_rd;
  assign wb_data_o  = w_data;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// tb/tb_riscv_alu_issue.sv - randomized self-checking bench for riscv_alu_issue
module tb_riscv_alu_issue;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_IDLE = 4'hF;

  logic              clk = 1'b0;
  logic              rstb = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = ALU_ADD;
  logic [XLEN-1:0]   in_rs1_val = '0, in_rs2_val = '0, in_imm = '0, in_pc = '0;
  logic [REG_AW-1:0] in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
  logic              in_rd_we = 1'b0;
  logic [1:0]        in_a_sel = 2'b00;
  logic              in_b_sel = 1'b0;
  logic              hold_i = 1'b0, flush_i = 1'b0;
  logic [3:0]        alu_op_o;
  logic [XLEN-1:0]   alu_a_o, alu_b_o;
  logic [XLEN-1:0]   alu_p_i = '0;
  logic              wb_valid_o, wb_we_o;
  logic [REG_AW-1:0] wb_rd_o;
  logic [XLEN-1:0]   wb_data_o;

  riscv_alu_issue #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rstb(rstb),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rd_we(in_rd_we), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .hold_i(hold_i), .flush_i(flush_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_p_i(alu_p_i),
    .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  // Registered ALU standing in for the real execute unit.
  always @(posedge clk) alu_p_i <= alu_ref(alu_op_o, alu_a_o, alu_b_o);

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] rs1_val, rs2_val, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
  } op_t;

  typedef struct {
    bit          v;
    logic [4:0]  rd;
    bit          we;
    logic [31:0] data;
  } slot_t;

  // Reference: ops waiting in acceptance order, plus the last two issue slots.
  op_t   q[$];
  slot_t h1, h2;
  bit    rdy_exp = 1'b1;
  int    vectors = 0;
  int    errors  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value a register source sees: the newest of the last two issued producers, else the file value.
  function automatic logic [31:0] src_val(input logic [4:0] src, input logic [31:0] rf);
    if (src != 0 && h1.v && h1.we && h1.rd == src) return h1.data;
    if (src != 0 && h2.v && h2.we && h2.rd == src) return h2.data;
    return rf;
  endfunction

  function automatic op_t mk(input logic [3:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] v1, input logic [31:0] v2,
                             input logic [31:0] imm, input logic bsel);
    op_t o;
    o.op = opc; o.a_sel = 2'b00; o.b_sel = bsel;
    o.rs1_val = v1; o.rs2_val = v2; o.imm = imm; o.pc = 32'h100;
    o.rs1 = rs1; o.rs2 = rs2; o.rd = rd; o.we = 1'b1;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.op = 4'($urandom_range(0, 9));
    o.a_sel = 2'($urandom_range(0, 3));
    o.b_sel = 1'($urandom_range(0, 1));
    o.rs1_val = $urandom; o.rs2_val = $urandom; o.imm = $urandom; o.pc = $urandom;
    o.rs1 = 5'($urandom_range(0, 3)); o.rs2 = 5'($urandom_range(0, 3));
    o.rd = 5'($urandom_range(0, 3));
    o.we = ($urandom_range(0, 9) != 0);
    return o;
  endfunction

  // One clock: drive at negedge, check against the model, then advance the model.
  task automatic step(input bit rst, input bit vld, input bit hold, input bit flush, input op_t op);
    op_t         head;
    slot_t       nx;
    logic [31:0] a, b;
    bit          issue, accept;
    @(negedge clk);
    rstb = rst; in_valid = vld; hold_i = hold; flush_i = flush;
    in_op = op.op; in_a_sel = op.a_sel; in_b_sel = op.b_sel;
    in_rs1_val = op.rs1_val; in_rs2_val = op.rs2_val; in_imm = op.imm; in_pc = op.pc;
    in_rs1_addr = op.rs1; in_rs2_addr = op.rs2; in_rd_addr = op.rd; in_rd_we = op.we;
    #1;
    chk("in_ready", in_ready, rdy_exp);
    chk("wb_valid", wb_valid_o, h2.v);
    if (h2.v) begin
      chk("wb_we", wb_we_o, h2.we);
      chk("wb_rd", wb_rd_o, h2.rd);
      chk("wb_data", wb_data_o, h2.data);
    end
    nx = '{v: 1'b0, rd: 5'd0, we: 1'b0, data: 32'd0};
    if (rst) begin
      chk("rst_op", alu_op_o, ALU_IDLE);
      chk("rst_a", alu_a_o, 0);
      chk("rst_b", alu_b_o, 0);
      q.delete();
      h1 = nx;
      h2 = nx;
      rdy_exp = 1'b1;
    end else begin
      accept = vld && rdy_exp;
      issue  = (q.size() > 0) && !hold && !flush;
      if (issue) begin
        head = q[0];
        a = (head.a_sel == 2'b01) ? head.pc :
            (head.a_sel == 2'b10) ? 32'd0 : src_val(head.rs1, head.rs1_val);
        b = head.b_sel ? head.imm : src_val(head.rs2, head.rs2_val);
        chk("issue_op", alu_op_o, head.op);
        chk("issue_a", alu_a_o, a);
        chk("issue_b", alu_b_o, b);
        nx = '{v: 1'b1, rd: head.rd, we: head.we, data: alu_ref(head.op, a, b)};
      end else begin
        chk("idle_op", alu_op_o, ALU_IDLE);
      end
      h2 = h1;
      h1 = nx;
      if (flush) begin
        q.delete();
      end else begin
        if (issue) void'(q.pop_front());
        if (accept) q.push_back(op);
      end
      rdy_exp = (q.size() < 2);
    end
  endtask

  op_t nop;

  initial begin
    nop = mk(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    h1 = '{v: 1'b0, rd: 5'd0, we: 1'b0, data: 32'd0};
    h2 = h1;

    // Reset state
    step(1, 0, 0, 0, nop);
    step(1, 0, 0, 0, nop);
    step(0, 0, 0, 0, nop);
    chk("reset_ready", in_ready, 1);
    chk("reset_wb_valid", wb_valid_o, 0);
    chk("reset_wb_rd", wb_rd_o, 0);
    chk("reset_wb_data", wb_data_o, 0);

    // ADD x3 = 5 + 7, writeback two cycles after issue
    step(0, 1, 0, 0, mk(ALU_ADD, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0));
    step(0, 0, 0, 0, nop);
    chk("t1_op", alu_op_o, ALU_ADD);
    chk("t1_a", alu_a_o, 5);
    chk("t1_b", alu_b_o, 7);
    step(0, 0, 0, 0, nop);
    step(0, 0, 0, 0, nop);
    chk("t1_wb_valid", wb_valid_o, 1);
    chk("t1_wb_rd", wb_rd_o, 3);
    chk("t1_wb_data", wb_data_o, 12);

    // Back-to-back dependency through X
    step(0, 1, 0, 0, mk(ALU_ADD, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0));
    step(0, 1, 0, 0, mk(ALU_SUB, 5'd4, 5'd3, 5'd6, 32'd0, 32'd2, 32'd0, 1'b0));
    step(0, 0, 0, 0, nop);
    chk("t2_op", alu_op_o, ALU_SUB);
    chk("t2_a_xfwd", alu_a_o, 12);
    chk("t2_b", alu_b_o, 2);
    repeat (3) step(0, 0, 0, 0, nop);

    // Dependency two ops back through W, then the same with rd = x0
    step(0, 1, 0, 0, mk(ALU_ADD, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0));
    step(0, 1, 0, 0, mk(ALU_OR, 5'd6, 5'd7, 5'd8, 32'd1, 32'd2, 32'd0, 1'b0));
    step(0, 1, 0, 0, mk(ALU_AND, 5'd5, 5'd3, 5'd0, 32'd0, 32'd0, 32'hF, 1'b1));
    step(0, 0, 0, 0, nop);
    chk("t3_a_wfwd", alu_a_o, 12);
    chk("t3_b_imm", alu_b_o, 32'hF);
    repeat (3) step(0, 0, 0, 0, nop);
    step(0, 1, 0, 0, mk(ALU_ADD, 5'd0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0));
    step(0, 1, 0, 0, mk(ALU_OR, 5'd6, 5'd7, 5'd8, 32'd1, 32'd2, 32'd0, 1'b0));
    step(0, 1, 0, 0, mk(ALU_AND, 5'd5, 5'd0, 5'd0, 32'h55, 32'd0, 32'hF, 1'b1));
    step(0, 0, 0, 0, nop);
    chk("t3_a_x0", alu_a_o, 32'h55);
    repeat (3) step(0, 0, 0, 0, nop);

    // Hold with continuous valid: buffer fills after two accepts
    step(0, 1, 1, 0, mk(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0));
    step(0, 1, 1, 0, mk(ALU_SUB, 5'd2, 5'd1, 5'd3, 32'd9, 32'd4, 32'd0, 1'b0));
    step(0, 1, 1, 0, mk(ALU_XOR, 5'd3, 5'd2, 5'd1, 32'd6, 32'd3, 32'd0, 1'b0));
    chk("t4_ready_low", in_ready, 0);
    chk("t4_idle", alu_op_o, ALU_IDLE);
    repeat (5) step(0, 0, 0, 0, nop);

    // Flush with an op in the ALU and one buffered
    step(0, 1, 0, 0, mk(ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd3, 32'd4, 32'd0, 1'b0));
    step(0, 1, 0, 0, mk(ALU_OR, 5'd2, 5'd0, 5'd0, 32'd8, 32'd1, 32'd0, 1'b0));
    step(0, 1, 0, 0, mk(ALU_ADD, 5'd2, 5'd0, 5'd0, 32'd8, 32'd8, 32'd0, 1'b0));
    step(0, 1, 0, 1, mk(ALU_SUB, 5'd3, 5'd0, 5'd0, 32'd1, 32'd1, 32'd0, 1'b0));
    step(0, 0, 0, 0, nop);
    chk("t5_ready", in_ready, 1);
    chk("t5_idle", alu_op_o, ALU_IDLE);
    repeat (3) step(0, 0, 0, 0, nop);

    // Reset mid-stream
    step(0, 1, 0, 0, mk(ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd3, 32'd4, 32'd0, 1'b0));
    step(0, 1, 0, 0, mk(ALU_ADD, 5'd2, 5'd0, 5'd0, 32'd5, 32'd4, 32'd0, 1'b0));
    step(1, 1, 0, 0, mk(ALU_ADD, 5'd3, 5'd0, 5'd0, 32'd5, 32'd5, 32'd0, 1'b0));
    step(0, 0, 0, 0, nop);
    chk("t6_wb_valid", wb_valid_o, 0);
    chk("t6_wb_rd", wb_rd_o, 0);
    chk("t6_wb_data", wb_data_o, 0);
    chk("t6_ready", in_ready, 1);
    step(0, 0, 0, 0, nop);
    chk("t6_no_retire", wb_valid_o, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, rnd_op());
    end
    repeat (4) step(0, 0, 0, 0, nop);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
